// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: data width, line idle level,
// FSM state encoding and the parity helper used when UART_TX_PARITY_EN is defined.
package fifo_uart_tx_pkg;

    localparam int   DATA_W  = 8;
    localparam logic TX_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    function automatic logic parity_of(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_cnt.sv
// Bit-period counter for the UART transmitter: bit_tick marks the last clk of each bit,
// and clr restarts the period so every frame begins on a fresh bit boundary.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a FIFO read port and sends them LSB first as async serial frames on tx.
// Define UART_TX_PARITY_EN to add a parity bit (sense set by PARITY_ODD) before the stop bits.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_ef,
    output logic              fifo_r,
    output logic              tx,
    output logic              busy
);

    if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1)
    begin : g_bad_param
        $error("fifo_uart_tx: illegal parameter combination");
    end

    state_t            state;
    logic [DATA_W-1:0] shift_reg;
    logic [2:0]        bit_cnt;
    logic              stop_cnt;
    logic              bit_tick;
    logic              baud_clr;
    logic              pop_ok;
`ifdef UART_TX_PARITY_EN
    logic              parity_bit;
`endif

    assign baud_clr = (state == ST_LOAD);
    assign pop_ok   = tx_en && !fifo_ef;

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (baud_clr),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            tx        <= TX_IDLE;
            fifo_r    <= 1'b0;
            busy      <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            // NOTE: the pop strobe defaults low each cycle so it can never stretch past one clk.
            fifo_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx <= TX_IDLE;
                    if (fifo_r) begin
                        state <= ST_LOAD;
                    end else if (pop_ok) begin
                        fifo_r <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    shift_reg <= fifo_data;
`ifdef UART_TX_PARITY_EN
                    parity_bit <= parity_of(fifo_data, PARITY_ODD[0]);
`endif
                    bit_cnt  <= '0;
                    stop_cnt <= 1'b0;
                    tx       <= 1'b0;
                    state    <= ST_START;
                end
                ST_START: begin
                    if (bit_tick) begin
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= ST_PARITY;
`else
                            tx    <= TX_IDLE;
                            state <= ST_STOP;
`endif
                        end else begin
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        tx    <= TX_IDLE;
                        state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_tick) begin
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            // Deciding the next pop here keeps back-to-back frames 2 clk apart.
                            state <= ST_IDLE;
                            if (pop_ok) begin
                                fifo_r <= 1'b1;
                            end else begin
                                busy <= 1'b0;
                            end
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= TX_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a depth-8 FIFO model and a byte scoreboard.
module tb_fifo_uart_tx;

    localparam int   CPB        = 4;
    localparam int   STOP_BITS  = 1;
    localparam logic PARITY_ODD = 1'b0;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 10 + STOP_BITS;
`else
    localparam int FRAME_BITS = 9 + STOP_BITS;
`endif
    localparam int FRAME_LEN = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_ef = 1'b1;
    logic       fifo_r;
    logic       tx;
    logic       busy;

    logic       push_valid = 1'b0;
    logic [7:0] push_byte = 8'h00;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    int cyc = 0;
    int pop_count = 0;
    int pop_cyc = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (STOP_BITS),
        .PARITY_ODD   (int'(PARITY_ODD))
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_en     (tx_en),
        .fifo_data (fifo_data),
        .fifo_ef   (fifo_ef),
        .fifo_r    (fifo_r),
        .tx        (tx),
        .busy      (busy)
    );

    // FIFO model: DataO and EF update on the edge that samples R or W.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_r) begin
            pop_count <= pop_count + 1;
            pop_cyc   <= cyc;
            if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        end
        if (push_valid && fifo_q.size() < 8) fifo_q.push_back(push_byte);
        fifo_ef <= (fifo_q.size() == 0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        push_valid = 1'b1;
        push_byte  = b;
        exp_q.push_back(b);
        @(negedge clk);
        push_valid = 1'b0;
    endtask

    function automatic logic exp_level(input logic [7:0] b, input int k);
        int bi;
        bi = k / CPB;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
`ifdef UART_TX_PARITY_EN
        if (bi == 9) return (^b) ^ PARITY_ODD;
`endif
        return 1'b1;
    endfunction

    // Waits at negedges for the start bit; reports how many high cycles preceded it.
    task automatic wait_start(input string tag, output int highs);
        logic seen;
        seen  = 1'b0;
        highs = 0;
        for (int i = 0; i < 300; i++) begin
            if (tx === 1'b0) begin
                seen = 1'b1;
                break;
            end
            highs++;
            @(negedge clk);
        end
        check({tag, "_start_seen"}, seen, 1'b1);
    endtask

    // Called at the first start-bit sample; ends one cycle after the last stop sample.
    task automatic capture_frame(input string tag, output logic par);
        logic [63:0] cap;
        logic [63:0] expw;
        logic [7:0]  b;
        logic [7:0]  dec;
        logic        busy_all;
        cap      = '0;
        expw     = '0;
        dec      = '0;
        par      = 1'b0;
        busy_all = 1'b1;
        check({tag, "_sb_nonempty"}, exp_q.size() > 0, 1'b1);
        b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        for (int k = 0; k < FRAME_LEN; k++) begin
            cap[k]   = tx;
            expw[k]  = exp_level(b, k);
            busy_all = busy_all & busy;
            if (k % CPB == CPB / 2) begin
                if (k / CPB >= 1 && k / CPB <= 8) dec[k/CPB-1] = tx;
                if (k / CPB == 9) par = tx;
            end
            @(negedge clk);
        end
        check({tag, "_wave"}, cap, expw);
        check({tag, "_byte"}, {56'd0, dec}, {56'd0, b});
        check({tag, "_busy"}, busy_all, 1'b1);
    endtask

    task automatic watch_idle(input int n, output logic tx_low, output logic busy_hi);
        tx_low  = 1'b0;
        busy_hi = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low = 1'b1;
            if (busy !== 1'b0) busy_hi = 1'b1;
        end
    endtask

    initial begin
        int         gap;
        int         pops0;
        logic       par;
        logic       tx_low;
        logic       busy_hi;
        logic [7:0] drop;

        // Reset state
        tick(3);
        check("rst_tx", tx, 1'b1);
        check("rst_fifo_r", fifo_r, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick(1);

        // 1: empty FIFO with tx_en high
        tx_en = 1'b1;
        pops0 = pop_count;
        watch_idle(100, tx_low, busy_hi);
        check("empty_no_pop", pop_count - pops0, 0);
        check("empty_tx_high", tx_low, 1'b0);
        check("empty_busy_low", busy_hi, 1'b0);

        // 2: single byte 0xA5
        pops0 = pop_count;
        push(8'hA5);
        wait_start("a5", gap);
        check("a5_latency", cyc - pop_cyc, 2);
        capture_frame("a5", par);
        tick(10);
        check("a5_one_pop", pop_count - pops0, 1);
        check("a5_busy_after", busy, 1'b0);

        // 3: back-to-back 0x00, 0xFF
        pops0 = pop_count;
        push(8'h00);
        push(8'hFF);
        wait_start("b2b0", gap);
        capture_frame("b2b0", par);
        wait_start("b2b1", gap);
        check("b2b_gap", gap, 2);
        capture_frame("b2b1", par);
        watch_idle(20, tx_low, busy_hi);
        check("b2b_two_pops", pop_count - pops0, 2);
        check("b2b_ef", fifo_ef, 1'b1);
        check("b2b_idle_after", tx_low, 1'b0);

        // 4: reset during data bit 3 of 0x3C
        push(8'h3C);
        wait_start("rst", gap);
        tick(16);
        rst = 1'b1;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_fifo_r", fifo_r, 1'b0);
        drop = exp_q.pop_front();
        check("midrst_dropped", {56'd0, drop}, 64'h3C);
        tick(3);
        check("midrst_ef", fifo_ef, 1'b1);
        rst = 1'b0;
        pops0 = pop_count;
        watch_idle(60, tx_low, busy_hi);
        check("postrst_no_pop", pop_count - pops0, 0);
        check("postrst_tx_high", tx_low, 1'b0);

        // 5a: tx_en low holds queued bytes, raising it sends both
        tx_en = 1'b0;
        pops0 = pop_count;
        push(8'h11);
        push(8'h22);
        watch_idle(30, tx_low, busy_hi);
        check("txen0_no_pop", pop_count - pops0, 0);
        check("txen0_tx_high", tx_low, 1'b0);
        tx_en = 1'b1;
        wait_start("en11", gap);
        capture_frame("en11", par);
        wait_start("en22", gap);
        check("en_gap", gap, 2);
        capture_frame("en22", par);
        check("en_two_pops", pop_count - pops0, 2);

        // 5b: tx_en dropped mid-frame
        tick(5);
        pops0 = pop_count;
        push(8'h33);
        push(8'h44);
        wait_start("drop33", gap);
        tx_en = 1'b0;
        capture_frame("drop33", par);
        watch_idle(60, tx_low, busy_hi);
        check("drop_one_pop", pop_count - pops0, 1);
        check("drop_idle_tx", tx_low, 1'b0);
        check("drop_ef", fifo_ef, 1'b0);
        check("drop_fifo_level", fifo_q.size(), 1);
        tx_en = 1'b1;
        wait_start("drain44", gap);
        capture_frame("drain44", par);
        tick(10);

`ifdef UART_TX_PARITY_EN
        // 6: parity frames
        push(8'hA5);
        push(8'h07);
        wait_start("parA5", gap);
        capture_frame("parA5", par);
        check("parA5_bit", par, 1'b0);
        wait_start("par07", gap);
        check("par_gap", gap, 2);
        capture_frame("par07", par);
        check("par07_bit", par, 1'b1);
        tick(10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
